// File: rtl/rr_priority_encoder_8to3.sv
// ============================================================================
// rr_priority_encoder_8to3 : registered 8-to-3 round-robin/fixed encoder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_priority_encoder_8to3 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] code,
  output logic       multi
);

  logic [2:0] ptr;
  logic [2:0] start;
  logic [7:0] rot;
  logic [2:0] offset;
  logic [2:0] grant;
  logic [3:0] ones;
  logic       capture;

  assign start = RR_EN ? ptr : 3'd0;

  // Rotate so the search always begins at bit 0, then map the hit back.
  always_comb begin
    rot    = 8'd0;
    offset = 3'd0;
    ones   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      rot[i] = req[3'(i) + start];
      ones   = ones + 4'(req[i]);
    end
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) offset = 3'(i);
    end
    grant = start + offset;
  end

  assign capture = en && (req != 8'd0) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      code      <= 3'd0;
      multi     <= 1'b0;
      ptr       <= 3'd0;
    end else if (capture) begin
      out_valid <= 1'b1;
      code      <= grant;
      multi     <= (ones > 4'd1);
      ptr       <= RR_EN ? (grant + 3'd1) : 3'd0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_priority_encoder_8to3.sv
// ============================================================================
// tb_rr_priority_encoder_8to3 : directed + random check of both RR_EN builds
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rr_priority_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'd0;
  logic       out_ready = 1'b0;

  logic       rr_valid, fx_valid;
  logic [2:0] rr_code, fx_code;
  logic       rr_multi, fx_multi;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, index 0 = round-robin build, 1 = fixed-priority build
  int m_valid [2];
  int m_code  [2];
  int m_multi [2];
  int m_ptr   [2];

  always #5 clk = ~clk;

  rr_priority_encoder_8to3 #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(rr_valid), .code(rr_code), .multi(rr_multi)
  );

  rr_priority_encoder_8to3 #(.RR_EN(1'b0)) u_fx (
    .clk(clk), .rst(rst), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(fx_valid), .code(fx_code), .multi(fx_multi)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input int c);
    int bits, start, idx;
    bit hit;
    if (rst) begin
      m_valid[c] = 0; m_code[c] = 0; m_multi[c] = 0; m_ptr[c] = 0;
      return;
    end
    if (en && req != 0 && (m_valid[c] == 0 || out_ready)) begin
      start = (c == 0) ? m_ptr[c] : 0;
      hit = 0;
      for (int k = 0; k < 8; k++) begin
        idx = (start + k) % 8;
        if (!hit && req[idx]) begin
          m_code[c] = idx;
          hit = 1;
        end
      end
      bits = 0;
      for (int k = 0; k < 8; k++) bits += req[k];
      m_multi[c] = (bits > 1);
      m_valid[c] = 1;
      if (c == 0) m_ptr[c] = (m_code[c] + 1) % 8;
    end else if (m_valid[c] == 1 && out_ready) begin
      m_valid[c] = 0;
    end
  endfunction

  // One clock: advance the model on the edge, compare outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("rr_valid", rr_valid, m_valid[0]);
    check("fx_valid", fx_valid, m_valid[1]);
    if (m_valid[0] == 1) begin
      check("rr_code", rr_code, m_code[0]);
      check("rr_multi", rr_multi, m_multi[0]);
    end
    if (m_valid[1] == 1) begin
      check("fx_code", fx_code, m_code[1]);
      check("fx_multi", fx_multi, m_multi[1]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("reset_code", rr_code, 0);
    check("reset_multi", rr_multi, 0);

    // Single request
    en = 1'b1; out_ready = 1'b1; req = 8'b0010_0000;
    tick();
    check("single_code", rr_code, 5);
    check("single_valid", rr_valid, 1);
    req = 8'd0;
    tick();
    check("single_drop", rr_valid, 0);

    // Pointer wrap: ptr is now 6
    req = 8'b0010_0001;
    tick();
    check("wrap_code0", rr_code, 0);
    tick();
    check("wrap_code5", rr_code, 5);

    // Round-robin sweep from a fresh pointer
    req = 8'd0;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("sweep_code", rr_code, k % 8);
      check("sweep_fixed", fx_code, 0);
    end

    // Backpressure
    req = 8'd0;
    do_reset();
    req = 8'h81; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_code", rr_code, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_code", rr_code, 7);

    // Enable low: nothing captured, pointer frozen
    req = 8'd0;
    tick();
    en = 1'b0; req = 8'hFF;
    for (int k = 0; k < 3; k++) tick();
    check("en0_valid", rr_valid, 0);
    en = 1'b1;
    tick();
    check("en0_ptr_kept", rr_code, 0);

    // Reset while stalled
    req = 8'd0;
    do_reset();
    req = 8'h40; out_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_code", rr_code, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", rr_valid, 0);
    check("mid_rst_code", rr_code, 0);
    req = 8'hFF; out_ready = 1'b1;
    tick();
    check("post_rst_code", rr_code, 0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       req = 8'd0;
        1:       req = 8'(1 << $urandom_range(0, 7));
        default: req = 8'($urandom);
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
